enemy_motion_ctrl: RTL and testbench
====================================

Name: enemy_motion_ctrl

Overview:
- Consumes the software AI command word Enemy_Data, written by the NIOS through the AI Avalon-MM slave.
- Steps the enemy position once per video frame.
- Produces Enemy_Loc, which the AI slave mirrors back to software and the renderer draws.
- Also flags enemy/player collision and missed frame ticks.

Parameters:
- X_MAX, 159, largest legal X coordinate (inclusive).
- Y_MAX, 119, largest legal Y coordinate (inclusive).
- SPAWN_X, 80, X coordinate at reset and on respawn.
- SPAWN_Y, 10, Y coordinate at reset and on respawn.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- FRAME_TICK  in  1  one-cycle pulse per frame (vsync-derived).
- Enemy_Data  in  16  command: [1:0] X dir, [3:2] Y dir (00 hold, 01 +1, 10 -1, 11 hold), [7:4] speed 0..15 units/frame, [8] chase mode, [14:9] reserved, [15] respawn request.
- Player_Loc  in  16  {X[15:8], Y[7:0]}.
- Enemy_Loc  out  16  {X[15:8], Y[7:0]}, registered.
- Busy  out  1  high while a frame update is in progress.
- Hit  out  1  high when published Enemy_Loc equals the latched player location.
- Overrun  out  1  one-cycle pulse when FRAME_TICK arrives while Busy.

Behaviour:
- Reset (asynchronous, immediate):
  - Enemy_Loc = {SPAWN_X, SPAWN_Y}, i.e. 0x500A at defaults; Busy = 0, Hit = 0, Overrun = 0.
  - FSM = IDLE; step counter = 0; resp_prev = 0; any in-flight update is discarded.
- FSM states: IDLE, STEP, UPDATE. Busy = (state != IDLE).
- IDLE, edge k with FRAME_TICK = 1:
  - Latch Enemy_Data into cmd_q and Player_Loc into ply_q; work_pos <= Enemy_Loc.
  - Respawn edge (Enemy_Data[15] = 1 and resp_prev = 0): work_pos <= {SPAWN_X, SPAWN_Y}, counter <= 0.
  - Otherwise counter <= Enemy_Data[7:4].
  - resp_prev <= Enemy_Data[15]; go to STEP.
- STEP, each edge:
  - counter = 0: go to UPDATE.
  - Otherwise move each axis one unit per its rule, decrement counter.
- Axis rule, normal mode:
  - +1 at max holds; -1 at 0 holds (clamp).
  - Dir 00 or 11 holds.
- Axis rule, chase mode (cmd_q[8] = 1):
  - Dir fields are ignored; each axis steps one unit toward the ply_q coordinate.
  - An axis already equal to ply_q holds. Chase never wraps.
- UPDATE, edge: Enemy_Loc <= work_pos; Hit <= (work_pos == ply_q); go to IDLE.
- Latency:
  - Enemy_Loc changes at edge k + speed + 2.
  - Busy is high for speed + 2 cycles.
  - Speed 0 still passes through UPDATE: Enemy_Loc is unchanged and Hit is re-evaluated.
- FRAME_TICK while Busy: the tick is ignored, and Overrun = 1 for the following cycle only.
- Enemy_Data and Player_Loc changes while Busy have no effect until the next accepted tick.
- Reserved bits are ignored.
- Held respawn bit: with bit 15 held high across frames, respawn happens once only. Bit 15 must return to 0 and be seen at a latch edge before the next respawn.
- Out-of-range coordinates on Player_Loc:
  - Chase targets them, but movement is still clamped to X_MAX/Y_MAX.
  - Hit then stays 0.

Optional Feature:
- ENEMY_WRAP_EN defined: in normal mode, +1 at max wraps to 0 and -1 at 0 wraps to max, per axis.
- Without it: clamp as above.
- Chase behaviour is identical in both builds.

Decomposition:
- Package enemy_pkg:
  - FSM state enum.
  - Coordinate typedef (8-bit).
  - Dir encoding constants.
  - Command field bit positions and the loc pack/unpack layout.
- Sub-module enemy_axis_step:
  - Combinational next-coordinate from {coord, dir, chase, target, max}.
  - Instantiated once for X and once for Y; wrap behaviour lives here under ENEMY_WRAP_EN.

Test Plan:
- Reset: assert RESET mid-STEP -> Enemy_Loc = 0x500A, Busy = 0, Hit = 0 immediately, without waiting for a clock; FSM is in IDLE.
- Move: Enemy_Data = 0x0031, tick at edge k -> Busy high 5 cycles; Enemy_Loc = 0x530A at edge k+5; Hit = 0.
- Clamp (no macro): X = 158, Enemy_Data = 0x0051 -> Enemy_Loc X = 159. With ENEMY_WRAP_EN the same case -> X = 3.
- Chase: Enemy_Loc = 0x500A, Player_Loc = 0x520A, Enemy_Data = 0x0140 -> Enemy_Loc = 0x520A, Hit = 1; Busy high 6 cycles.
- Respawn: after moves, Enemy_Data = 0x8000, tick -> Enemy_Loc = 0x500A. Hold 0x8000, tick with Enemy_Loc moved to 0x510A beforehand -> unchanged 0x510A.
- Overrun: Enemy_Data = 0x00F1, second tick 3 cycles after the first -> Overrun pulses exactly 1 cycle; X advances by 15 only once.

Source files
------------

// File: rtl/enemy_pkg.sv
// Shared types and field layout for the enemy motion controller.
package enemy_pkg;

  typedef logic [7:0] coord_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STEP   = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_INC  = 2'b01;
  localparam logic [1:0] DIR_DEC  = 2'b10;
  localparam logic [1:0] DIR_HOLD2 = 2'b11;

  localparam int CMD_XDIR  = 0;
  localparam int CMD_YDIR  = 2;
  localparam int CMD_SPD   = 4;
  localparam int CMD_CHASE = 8;
  localparam int CMD_RESP  = 15;

  function automatic coord_t loc_x(input logic [15:0] l);
    return l[15:8];
  endfunction

  function automatic coord_t loc_y(input logic [15:0] l);
    return l[7:0];
  endfunction

  function automatic logic [15:0] loc_pack(input coord_t x,
                                           input coord_t y);
    return {x, y};
  endfunction

endpackage

// File: rtl/enemy_axis_step.sv
// One-unit next-coordinate for a single axis.
// ENEMY_WRAP_EN selects wrap instead of clamp in normal mode.
module enemy_axis_step
  import enemy_pkg::*;
(
  input  coord_t     coord_i,
  input  logic [1:0] dir_i,
  input  logic       chase_i,
  input  coord_t     target_i,
  input  coord_t     max_i,
  output coord_t     next_o
);

  always_comb begin
    next_o = coord_i;
    if (chase_i) begin
      // toward target, never past the legal range
      if (target_i > coord_i && coord_i < max_i)
        next_o = coord_i + 8'd1;
      else if (target_i < coord_i)
        next_o = coord_i - 8'd1;
    end else begin
      unique case (dir_i)
        DIR_INC: begin
          if (coord_i >= max_i)
`ifdef ENEMY_WRAP_EN
            next_o = '0;
`else
            next_o = max_i;
`endif
          else
            next_o = coord_i + 8'd1;
        end
        DIR_DEC: begin
          if (coord_i == '0)
`ifdef ENEMY_WRAP_EN
            next_o = max_i;
`else
            next_o = '0;
`endif
          else
            next_o = coord_i - 8'd1;
        end
        default: next_o = coord_i;
      endcase
    end
  end

endmodule

// File: rtl/enemy_motion_ctrl.sv
// Per-frame enemy position stepper with chase, respawn and hit/overrun flags.
// Optional macro ENEMY_WRAP_EN: wrap at the playfield edges in normal mode.
module enemy_motion_ctrl
  import enemy_pkg::*;
#(
  parameter coord_t X_MAX   = 8'd159,
  parameter coord_t Y_MAX   = 8'd119,
  parameter coord_t SPAWN_X = 8'd80,
  parameter coord_t SPAWN_Y = 8'd10
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FRAME_TICK,
  input  logic [15:0] Enemy_Data,
  input  logic [15:0] Player_Loc,
  output logic [15:0] Enemy_Loc,
  output logic        Busy,
  output logic        Hit,
  output logic        Overrun
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  xdir_q, xdir_d;
  logic [1:0]  ydir_q, ydir_d;
  logic        chase_q, chase_d;
  logic [15:0] ply_q, ply_d;
  coord_t      wx_q, wx_d;
  coord_t      wy_q, wy_d;
  logic        rp_q, rp_d;
  logic [15:0] loc_q, loc_d;
  logic        hit_q, hit_d;
  logic        ovr_q, ovr_d;
  coord_t      nx, ny;
  logic        resp_edge;
  logic        unused_rsvd;

  assign unused_rsvd = ^Enemy_Data[14:9];
  assign resp_edge   = Enemy_Data[CMD_RESP] & ~rp_q;

  enemy_axis_step u_x (
    .coord_i  (wx_q),
    .dir_i    (xdir_q),
    .chase_i  (chase_q),
    .target_i (loc_x(ply_q)),
    .max_i    (X_MAX),
    .next_o   (nx)
  );

  enemy_axis_step u_y (
    .coord_i  (wy_q),
    .dir_i    (ydir_q),
    .chase_i  (chase_q),
    .target_i (loc_y(ply_q)),
    .max_i    (Y_MAX),
    .next_o   (ny)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xdir_d  = xdir_q;
    ydir_d  = ydir_q;
    chase_d = chase_q;
    ply_d   = ply_q;
    wx_d    = wx_q;
    wy_d    = wy_q;
    rp_d    = rp_q;
    loc_d   = loc_q;
    hit_d   = hit_q;
    ovr_d   = FRAME_TICK && (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (FRAME_TICK) begin
          xdir_d  = Enemy_Data[CMD_XDIR +: 2];
          ydir_d  = Enemy_Data[CMD_YDIR +: 2];
          chase_d = Enemy_Data[CMD_CHASE];
          ply_d   = Player_Loc;
          rp_d    = Enemy_Data[CMD_RESP];
          state_d = S_STEP;
          if (resp_edge) begin
            wx_d  = SPAWN_X;
            wy_d  = SPAWN_Y;
            cnt_d = '0;
          end else begin
            wx_d  = loc_x(loc_q);
            wy_d  = loc_y(loc_q);
            cnt_d = Enemy_Data[CMD_SPD +: 4];
          end
        end
      end
      S_STEP: begin
        if (cnt_q == '0) begin
          state_d = S_UPDATE;
        end else begin
          wx_d  = nx;
          wy_d  = ny;
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_UPDATE: begin
        loc_d   = loc_pack(wx_q, wy_q);
        hit_d   = (loc_pack(wx_q, wy_q) == ply_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      xdir_q  <= DIR_HOLD;
      ydir_q  <= DIR_HOLD;
      chase_q <= 1'b0;
      ply_q   <= '0;
      wx_q    <= SPAWN_X;
      wy_q    <= SPAWN_Y;
      rp_q    <= 1'b0;
      loc_q   <= loc_pack(SPAWN_X, SPAWN_Y);
      hit_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xdir_q  <= xdir_d;
      ydir_q  <= ydir_d;
      chase_q <= chase_d;
      ply_q   <= ply_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      rp_q    <= rp_d;
      loc_q   <= loc_d;
      hit_q   <= hit_d;
      ovr_q   <= ovr_d;
    end
  end

  assign Enemy_Loc = loc_q;
  assign Busy      = (state_q != S_IDLE);
  assign Hit       = hit_q;
  assign Overrun   = ovr_q;

endmodule

// File: tb/tb_enemy_motion_ctrl.sv
// Directed plus randomized frame bench for enemy_motion_ctrl.
// Reference model works on whole frames with plain arithmetic.
module tb_enemy_motion_ctrl;

  localparam int XMAX = 159;
  localparam int YMAX = 119;
  localparam int SPX  = 80;
  localparam int SPY  = 10;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        FRAME_TICK;
  logic [15:0] Enemy_Data;
  logic [15:0] Player_Loc;
  logic [15:0] Enemy_Loc;
  logic        Busy;
  logic        Hit;
  logic        Overrun;

  int checks = 0;
  int errors = 0;

  int m_x, m_y;
  bit m_rp;
  bit m_hit;

  enemy_motion_ctrl dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .FRAME_TICK (FRAME_TICK),
    .Enemy_Data (Enemy_Data),
    .Player_Loc (Player_Loc),
    .Enemy_Loc  (Enemy_Loc),
    .Busy       (Busy),
    .Hit        (Hit),
    .Overrun    (Overrun)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Net displacement of one axis over a whole frame of s units.
  function automatic int axis_move(input int c, input int dir, input bit ch,
                                   input int t, input int mx, input int s);
    int n;
    n = c;
    if (ch) begin
      if (t > c) begin
        n = (t - c < s) ? t : c + s;
        if (n > mx) n = mx;
      end else if (t < c) begin
        n = (c - t < s) ? t : c - s;
      end
    end else if (dir == 1) begin
`ifdef ENEMY_WRAP_EN
      n = (c + s) % (mx + 1);
`else
      n = (c + s > mx) ? mx : c + s;
`endif
    end else if (dir == 2) begin
`ifdef ENEMY_WRAP_EN
      n = (c - s + mx + 1) % (mx + 1);
`else
      n = (c - s < 0) ? 0 : c - s;
`endif
    end
    return n;
  endfunction

  task automatic model_reset();
    m_x   = SPX;
    m_y   = SPY;
    m_rp  = 1'b0;
    m_hit = 1'b0;
  endtask

  // One accepted frame; tick2 > 0 injects a second tick on busy cycle tick2.
  task automatic frame(input logic [15:0] d, input logic [15:0] p,
                       input int tick2, input bit noise, input string tag);
    int s, n, ov, px, py, old;
    bit early;
    old = (m_x << 8) | m_y;
    @(negedge CLK);
    Enemy_Data = d;
    Player_Loc = p;
    FRAME_TICK = 1'b1;
    px = int'(p[15:8]);
    py = int'(p[7:0]);
    if (d[15] && !m_rp) begin
      m_x = SPX;
      m_y = SPY;
      s = 0;
    end else begin
      s = int'(d[7:4]);
    end
    m_rp = d[15];
    m_x = axis_move(m_x, int'(d[1:0]), d[8], px, XMAX, s);
    m_y = axis_move(m_y, int'(d[3:2]), d[8], py, YMAX, s);
    m_hit = (m_x == px) && (m_y == py);
    @(negedge CLK);
    FRAME_TICK = 1'b0;
    n = 0;
    ov = 0;
    early = 1'b0;
    while (Busy && n < 60) begin
      n++;
      FRAME_TICK = (tick2 > 0 && n == tick2);
      if (Overrun) ov++;
      if (int'(Enemy_Loc) != old) early = 1'b1;
      if (noise) begin
        Enemy_Data = 16'($urandom);
        Player_Loc = 16'($urandom);
      end
      @(negedge CLK);
    end
    FRAME_TICK = 1'b0;
    check({tag, ".busy_cycles"}, n, s + 2);
    check({tag, ".loc_early"}, int'(early), 0);
    check({tag, ".loc"}, int'(Enemy_Loc), (m_x << 8) | m_y);
    check({tag, ".hit"}, int'(Hit), int'(m_hit));
    check({tag, ".overrun"}, ov, (tick2 > 0) ? 1 : 0);
  endtask

  initial begin
    RESET      = 1'b1;
    FRAME_TICK = 1'b0;
    Enemy_Data = '0;
    Player_Loc = '0;
    model_reset();
    #1;
    check("reset.loc", int'(Enemy_Loc), 16'h500A);
    check("reset.busy", int'(Busy), 0);
    check("reset.hit", int'(Hit), 0);
    check("reset.ovr", int'(Overrun), 0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

    frame(16'h0031, 16'h0000, 0, 1'b0, "move");
    check("move.plan", int'(Enemy_Loc), 16'h530A);

    frame(16'h8000, 16'h0000, 0, 1'b0, "respawn1");
    check("respawn1.plan", int'(Enemy_Loc), 16'h500A);

    frame(16'h0140, 16'h520A, 0, 1'b0, "chase");
    check("chase.plan", int'(Enemy_Loc), 16'h520A);
    check("chase.hit_plan", int'(Hit), 1);

    frame(16'h8000, 16'h0000, 0, 1'b0, "respawn2");
    frame(16'h8011, 16'h0000, 0, 1'b0, "held_move");
    frame(16'h8000, 16'h0000, 0, 1'b0, "held_resp");
    check("held_resp.plan", int'(Enemy_Loc), 16'h510A);

    frame(16'h0000, 16'h510A, 0, 1'b0, "speed0");
    check("speed0.hit_plan", int'(Hit), 1);

    for (int i = 0; i < 5; i++)
      frame(16'h00F1, 16'h0000, 0, 1'b0, "ramp");
    frame(16'h0021, 16'h0000, 0, 1'b0, "ramp2");
    check("edge.x158", int'(Enemy_Loc[15:8]), 158);
    frame(16'h0051, 16'h0000, 0, 1'b0, "edge");
`ifdef ENEMY_WRAP_EN
    check("edge.plan", int'(Enemy_Loc[15:8]), 3);
`else
    check("edge.plan", int'(Enemy_Loc[15:8]), 159);
`endif

    frame(16'h8000, 16'h0000, 0, 1'b0, "respawn3");
    frame(16'h00F1, 16'h0000, 3, 1'b0, "overrun");
    check("overrun.plan", int'(Enemy_Loc), 16'h5F0A);

    frame(16'h0FF0, 16'hFFFF, 0, 1'b0, "chase_oor");

    // reset while stepping
    @(negedge CLK);
    Enemy_Data = 16'h00F1;
    FRAME_TICK = 1'b1;
    @(negedge CLK);
    FRAME_TICK = 1'b0;
    repeat (3) @(negedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    check("midreset.loc", int'(Enemy_Loc), 16'h500A);
    check("midreset.busy", int'(Busy), 0);
    check("midreset.hit", int'(Hit), 0);
    model_reset();
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("midreset.idle", int'(Busy), 0);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] d, p;
      d = 16'($urandom);
      d[15] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        p[15:8] = 8'(m_x + $urandom_range(0, 6) - 3);
        p[7:0]  = 8'(m_y + $urandom_range(0, 6) - 3);
      end else begin
        p = 16'($urandom);
      end
      frame(d, p, 0, 1'b1, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
